// File: rtl/preg_alloc_ctrl_pkg.sv
// rtl/preg_alloc_ctrl_pkg.sv - shared physical-register types for rename, map table and ROB
//
// Purpose: constants and types common to the rename-stage blocks.
//   NUM_PREGS     physical registers (power of two)
//   NUM_AREGS     architectural registers, mapped to p0..p(NUM_AREGS-1) at reset
//   PREG_W        physical tag width
//   preg_t        physical register tag
//   alloc_state_e allocation controller state (NORMAL, RECOVER)

package preg_alloc_ctrl_pkg;

  localparam int NUM_PREGS = 128;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/preg_ring.sv
// rtl/preg_ring.sv - free-list ring storage with reset initialisation
//
// Purpose: NUM_PREGS x PREG_W storage for the free list. At reset, entries
// 0..NUM_PREGS-NUM_AREGS-1 hold tags NUM_AREGS..NUM_PREGS-1 and the rest hold 0.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   wr_en        write strobe
//   wr_addr      write index
//   wr_data      tag written
//   rd_addr      asynchronous read index
//   rd_data      tag at rd_addr

module preg_ring #(
  parameter int NUM_PREGS = preg_alloc_ctrl_pkg::NUM_PREGS,
  parameter int NUM_AREGS = preg_alloc_ctrl_pkg::NUM_AREGS,
  parameter int PREG_W    = preg_alloc_ctrl_pkg::PREG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PREG_W-1:0] wr_addr,
  input  logic [PREG_W-1:0] wr_data,
  input  logic [PREG_W-1:0] rd_addr,
  output logic [PREG_W-1:0] rd_data
);

  import preg_alloc_ctrl_pkg::*;

  logic [PREG_W-1:0] mem [NUM_PREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem[i] <= (i < NUM_PREGS - NUM_AREGS) ? PREG_W'(NUM_AREGS + i) : '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/preg_alloc_ctrl.sv
// rtl/preg_alloc_ctrl.sv - physical-register free-list allocation controller
//
// Purpose: owns the circular free list, grants one tag per cycle to rename,
// accepts one released tag per cycle from commit, and checkpoints/restores
// the head pointer around branches with a one-cycle RECOVER stall.
// Optional feature macro: FREELIST_BYPASS_EN (empty-list release bypass).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   alloc_req    rename wants a destination tag
//   alloc_ready  tag available and not recovering
//   alloc_preg   tag offered to rename
//   free_valid   commit releases free_preg
//   free_preg    released tag
//   ckpt_save    snapshot head after this cycle's allocation
//   mispredict   restore head from snapshot
//   free_count   number of free tags
//   recovering   controller in RECOVER

module preg_alloc_ctrl #(
  parameter int NUM_PREGS = preg_alloc_ctrl_pkg::NUM_PREGS,
  parameter int NUM_AREGS = preg_alloc_ctrl_pkg::NUM_AREGS,
  parameter int PREG_W    = preg_alloc_ctrl_pkg::PREG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  output logic              alloc_ready,
  output logic [PREG_W-1:0] alloc_preg,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg,
  input  logic              ckpt_save,
  input  logic              mispredict,
  output logic [PREG_W:0]   free_count,
  output logic              recovering
);

  import preg_alloc_ctrl_pkg::*;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [PREG_W:0] ptr_t;

  localparam ptr_t RESET_TAIL = ptr_t'(NUM_PREGS - NUM_AREGS);
  localparam ptr_t FULL_COUNT = ptr_t'(NUM_PREGS);

  ptr_t              head_q;
  ptr_t              tail_q;
  ptr_t              snap_q;
  ptr_t              head_d;
  alloc_state_e      state_q;
  logic [PREG_W-1:0] ring_rd;

  logic in_normal;
  logic empty;
  logic release_ok;
  logic mispredict_fire;
  logic alloc_fire;
  logic bypass_hit;
  logic bypass_fire;
  logic ring_wr;

  assign free_count      = tail_q - head_q;
  assign in_normal       = (state_q == NORMAL);
  assign empty           = (free_count == '0);
  assign release_ok      = free_valid && (free_preg != '0) && (free_count != FULL_COUNT);
  assign mispredict_fire = in_normal && mispredict;

`ifdef FREELIST_BYPASS_EN
  // Hand a same-cycle release straight to rename when the ring is empty.
  assign bypass_hit = empty && in_normal && !mispredict && free_valid && (free_preg != '0);
`else
  assign bypass_hit = 1'b0;
`endif

  // Ready depends only on registered state (plus the release port when
  // bypassing), never on alloc_req.
  assign alloc_ready = (in_normal && !empty) || bypass_hit;
  assign alloc_preg  = bypass_hit ? free_preg : ring_rd;
  assign recovering  = (state_q == RECOVER);

  // A mispredict cycle suppresses the grant even though ready is high.
  assign alloc_fire  = alloc_req && in_normal && !empty && !mispredict;
  assign bypass_fire = alloc_req && bypass_hit;

  // A bypassed tag never enters the ring, so neither pointer moves.
  assign ring_wr = release_ok && !bypass_fire;

  always_comb begin
    head_d = head_q;
    if (mispredict_fire) begin
      head_d = snap_q;
    end else if (alloc_fire) begin
      head_d = head_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= RESET_TAIL;
      snap_q  <= '0;
      state_q <= NORMAL;
    end else begin
      head_q <= head_d;
      if (ring_wr) begin
        tail_q <= tail_q + ptr_t'(1);
      end
      case (state_q)
        NORMAL: begin
          // Mispredict wins over a simultaneous save.
          if (mispredict) begin
            state_q <= RECOVER;
          end else if (ckpt_save) begin
            snap_q <= head_d;
          end
        end
        RECOVER: state_q <= NORMAL;
        default: state_q <= NORMAL;
      endcase
    end
  end

  preg_ring #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_AREGS (NUM_AREGS),
    .PREG_W    (PREG_W)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ring_wr),
    .wr_addr (tail_q[PREG_W-1:0]),
    .wr_data (free_preg),
    .rd_addr (head_q[PREG_W-1:0]),
    .rd_data (ring_rd)
  );

  // Commit must never release into a full free list.
  a_no_release_when_full: assert property (@(posedge clk) disable iff (reset)
    !(free_valid && (free_preg != '0) && (free_count == FULL_COUNT)));

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// tb/tb_preg_alloc_ctrl.sv - self-checking bench for preg_alloc_ctrl

module tb_preg_alloc_ctrl;

  localparam int NP = 128;
  localparam int NA = 32;
  localparam int W  = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         alloc_req;
  logic         alloc_ready;
  logic [W-1:0] alloc_preg;
  logic         free_valid;
  logic [W-1:0] free_preg;
  logic         ckpt_save;
  logic         mispredict;
  logic [W:0]   free_count;
  logic         recovering;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: every tag ever placed in the free list, in order,
  // plus how many have been handed out; a checkpoint is just that count.
  int order[$];
  int n_alloc;
  int n_push;
  int snap;
  bit rec;

  preg_alloc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_preg  (alloc_preg),
    .free_valid  (free_valid),
    .free_preg   (free_preg),
    .ckpt_save   (ckpt_save),
    .mispredict  (mispredict),
    .free_count  (free_count),
    .recovering  (recovering)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    order.delete();
    for (int i = 0; i < NP - NA; i++) order.push_back(NA + i);
    n_alloc = 0;
    n_push  = NP - NA;
    snap    = 0;
    rec     = 1'b0;
  endtask

  task automatic idle_inputs();
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_preg  = '0;
    ckpt_save  = 1'b0;
    mispredict = 1'b0;
  endtask

  // One clock: drive, check outputs at the falling edge, advance the model.
  task automatic step(input bit req, input bit fv, input int fp, input bit ck, input bit mp);
    int  free;
    bit  byp;
    bit  ready;
    bit  rel;
    alloc_req  = req;
    free_valid = fv;
    free_preg  = W'(fp);
    ckpt_save  = ck;
    mispredict = mp;
    @(negedge clk);
    free = n_push - n_alloc;
    byp  = 1'b0;
`ifdef FREELIST_BYPASS_EN
    byp = (free == 0) && !rec && !mp && fv && (fp != 0);
`endif
    ready = byp || (!rec && free > 0);
    check("alloc_ready", alloc_ready, ready);
    if (ready) check("alloc_preg", alloc_preg, byp ? fp : order[n_alloc]);
    check("free_count", free_count, free);
    check("recovering", recovering, rec);
    rel = fv && (fp != 0) && (free < NP);
    if (rec) begin
      if (rel) begin order.push_back(fp); n_push++; end
      rec = 1'b0;
    end else if (mp) begin
      n_alloc = snap;
      rec     = 1'b1;
      if (rel) begin order.push_back(fp); n_push++; end
    end else begin
      if (!(byp && req)) begin
        if (req && free > 0) n_alloc++;
        if (rel) begin order.push_back(fp); n_push++; end
      end
      if (ck) snap = n_alloc;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int free;
    bit fv;
    bit mp;
    int fp;

    idle_inputs();
    reset = 1'b1;
    #12;
    check("rst_ready", alloc_ready, 1);
    check("rst_preg", alloc_preg, 32);
    check("rst_free_count", free_count, 96);
    check("rst_recovering", recovering, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Drain the whole list in order.
    for (int i = 0; i < NP - NA; i++) begin
      check("grant_seq", alloc_preg, 32 + i);
      step(1, 0, 0, 0, 0);
    end
    check("empty_ready", alloc_ready, 0);
    check("empty_count", free_count, 0);

    // Release into an empty list; tag is grantable the next cycle.
    step(0, 1, 40, 0, 0);
    check("refill_ready", alloc_ready, 1);
    check("refill_preg", alloc_preg, 40);
    step(1, 0, 0, 0, 0);
`ifdef FREELIST_BYPASS_EN
    step(1, 1, 41, 0, 0);
    check("bypass_count", free_count, 0);
`endif

    // Checkpoint at p32, allocate p33/p34, then mispredict.
    do_reset();
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("rec_flag", recovering, 1);
    check("rec_ready", alloc_ready, 0);
    step(1, 0, 0, 0, 0);
    check("rec_done_preg", alloc_preg, 33);
    check("rec_done_count", free_count, 95);

    // Mispredict with a simultaneous save uses the old snapshot.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    check("mp_ck_preg", alloc_preg, 33);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("mp_ck_later_preg", alloc_preg, 33);

    // Release of p0 is ignored.
    step(0, 1, 0, 0, 0);
    check("p0_count", free_count, 95);

    // Reset in the middle of RECOVER with alloc_req high.
    step(0, 0, 0, 0, 1);
    alloc_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("rst_rec_flag", recovering, 0);
    check("rst_rec_preg", alloc_preg, 32);
    check("rst_rec_count", free_count, 96);
    check("rst_rec_ready", alloc_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle_inputs();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      free = n_push - n_alloc;
      fv   = ($urandom_range(0, 1) == 1) && (free < NP);
      fp   = $urandom_range(0, NP - 1);
      mp   = ($urandom_range(0, 19) == 0) && (n_push + 1 - snap <= NP);
      step($urandom_range(0, 9) < 6, fv, fp, $urandom_range(0, 9) == 0, mp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
